regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the ARM-subset CPU core; successor to the 2-read/1-write register bank.
- Generalised in read-port count, register count and data width.
- Adds a second byte-enabled write port for LDRB/LDR writeback, per-register busy scoreboard for load-use interlock, and async clear.
- Sits between decode (reads) and writeback (writes); PC remains a separate module.

Parameters:
- ADDR_W, 4, register address width.
- NREG, 15, implemented registers (addresses 0..NREG-1); NREG <= 2**ADDR_W.
- DATA_W, 32, register width; must be a multiple of 8.
- NRD, 3, read ports (1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rd_addr  input  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NRD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W].
- rd_busy  output  NRD  registered scoreboard bit of each read address.
- wp0_en  input  1  ALU writeback enable (full word).
- wp0_addr  input  ADDR_W  ALU writeback address.
- wp0_data  input  DATA_W  ALU writeback data.
- wp1_en  input  1  load writeback enable.
- wp1_addr  input  ADDR_W  load writeback address.
- wp1_be  input  DATA_W/8  load byte enables; bit k selects bits [8k+7:8k].
- wp1_data  input  DATA_W  load writeback data (lane-aligned).
- sb_set  input  1  mark sb_addr busy (load issued).
- sb_addr  input  ADDR_W  register to mark busy.

Behaviour:
- Reset (reset=0, async): all NREG registers = 0, busy bits = 0, rd_data = 0, rd_busy = 0. Held while low; a write in flight when reset asserts is lost.
- Read: 1-cycle latency. rd_data[i] and rd_busy[i] update on every posedge from rd_addr[i] sampled at that edge. No read enable.
- Write: on posedge, wp0_en writes all DATA_W bits. wp1_en writes only lanes with wp1_be=1; other lanes keep old value. wp1_en with wp1_be=0 is a no-op for data but still clears busy.
- Write collision (same address, both enabled): per byte lane, wp0 wins; wp1 lanes not covered by wp0 are none, so the result equals wp0_data. Busy is still cleared by wp1.
- Out of range (addr >= NREG): writes are ignored; reads return 0 with busy=0; sb_set is ignored.
- Scoreboard: per-register busy flop.
  - sb_set sets busy[sb_addr].
  - wp1_en clears busy[wp1_addr].
  - wp0 does not affect busy.
  - Same-cycle set and clear on the same address: set wins (back-to-back loads to one register).
  - sb_set on an already-busy register leaves it busy.
- Read-during-write, same address, same edge: behaviour depends on REGFILE_BYPASS_EN. Busy readback follows the same rule, using the post-update busy value when bypass is enabled and the pre-update value otherwise.
- No internal FSM beyond the per-register state. All outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose address matches an active write in the same cycle returns the newly written value, merged per lane with wp0-over-wp1 priority and old data in unwritten lanes. rd_busy returns the post-update scoreboard value.
- Undefined: the read returns the pre-write register contents and pre-update busy. The pipeline must stall one cycle for such hazards.

Test Plan:
- Reset low mid-write (wp0_en=1, addr 3, data 0xDEADBEEF), release, read r3 -> rd_data=0, rd_busy=0.
- wp0 r5=0x12345678; next cycle read r5 on all NRD ports -> each port returns 0x12345678 one cycle later.
- r2=0xAABBCCDD, then wp1 r2 be=4'b0010 data 0x00001100 -> r2 reads 0xAABB11DD.
- Same edge wp0 r7=0x11111111 and wp1 r7 be=4'hF data 0x22222222 -> r7=0x11111111. If r7 was busy, it is now clear.
- sb_set r4 -> rd_busy=1 on r4 reads. Same edge sb_set r4 and wp1 r4 -> still busy. Next wp1 r4 alone -> busy=0.
- Read r9 while wp0 writes r9=0xCAFEF00D (old 0x0): with REGFILE_BYPASS_EN -> 0xCAFEF00D; without -> 0x00000000, then 0xCAFEF00D on the next read. Address 15 (NREG=15) -> always reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NRD registered read ports, full-word + byte-enabled write ports,
// per-register load busy scoreboard. Define REGFILE_BYPASS_EN for same-edge write-to-read forwarding.

module regfile_mp_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W/8-1:0] be1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic              set,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] q_nxt,
  output logic              busy,
  output logic              busy_nxt
);
  // wp0 owns every lane it writes, so it overrides wp1 lane by lane
  always_comb begin
    q_nxt = q;
    for (int k = 0; k < DATA_W/8; k++) begin
      if (we0)                q_nxt[8*k +: 8] = d0[8*k +: 8];
      else if (we1 && be1[k]) q_nxt[8*k +: 8] = d1[8*k +: 8];
    end
  end

  // set beats clear so back-to-back loads to one register stay interlocked
  assign busy_nxt = set | (busy & ~we1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      q    <= q_nxt;
      busy <= busy_nxt;
    end
  end
endmodule

module regfile_mp #(
  parameter int ADDR_W = 4,
  parameter int NREG   = 15,
  parameter int DATA_W = 32,
  parameter int NRD    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wp0_en,
  input  logic [ADDR_W-1:0]     wp0_addr,
  input  logic [DATA_W-1:0]     wp0_data,
  input  logic                  wp1_en,
  input  logic [ADDR_W-1:0]     wp1_addr,
  input  logic [DATA_W/8-1:0]   wp1_be,
  input  logic [DATA_W-1:0]     wp1_data,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [NREG-1:0][DATA_W-1:0] q, q_nxt;
  logic [NREG-1:0]             busy, busy_nxt;

  // addresses >= NREG match no cell, so out-of-range writes/sets fall away
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    regfile_mp_cell #(.DATA_W(DATA_W)) u_cell (
      .clk      (clk),
      .reset    (reset),
      .we0      (wp0_en && (wp0_addr == ADDR_W'(r))),
      .we1      (wp1_en && (wp1_addr == ADDR_W'(r))),
      .be1      (wp1_be),
      .d0       (wp0_data),
      .d1       (wp1_data),
      .set      (sb_set && (sb_addr == ADDR_W'(r))),
      .q        (q[r]),
      .q_nxt    (q_nxt[r]),
      .busy     (busy[r]),
      .busy_nxt (busy_nxt[r])
    );
  end

  logic [NRD-1:0][DATA_W-1:0] rd_d_nxt, rd_d_q;
  logic [NRD-1:0]             rd_b_nxt, rd_b_q;

  always_comb begin
    rd_d_nxt = '0;
    rd_b_nxt = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = 0; r < NREG; r++) begin
        if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          rd_d_nxt[i] = BYPASS ? q_nxt[r] : q[r];
          rd_b_nxt[i] = BYPASS ? busy_nxt[r] : busy[r];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_d_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_d_q <= rd_d_nxt;
      rd_b_q <= rd_b_nxt;
    end
  end

  assign rd_data = rd_d_q;
  assign rd_busy = rd_b_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized + directed bench for regfile_mp against an array-based register model.
module tb_regfile_mp;
  localparam int ADDR_W = 4;
  localparam int NREG   = 15;
  localparam int DATA_W = 32;
  localparam int NRD    = 3;
  localparam int NB     = DATA_W/8;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wp0_en, wp1_en, sb_set;
  logic [ADDR_W-1:0]     wp0_addr, wp1_addr, sb_addr;
  logic [DATA_W-1:0]     wp0_data, wp1_data;
  logic [NB-1:0]         wp1_be;

  regfile_mp #(.ADDR_W(ADDR_W), .NREG(NREG), .DATA_W(DATA_W), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wp0_en(wp0_en), .wp0_addr(wp0_addr), .wp0_data(wp0_data),
    .wp1_en(wp1_en), .wp1_addr(wp1_addr), .wp1_be(wp1_be), .wp1_data(wp1_data),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  always #5 clk = ~clk;

  // model state
  logic [DATA_W-1:0] mem [NREG];
  logic              bsy [NREG];
  logic [DATA_W-1:0] exp_d [NRD];
  logic              exp_b [NRD];
  bit                chk_en = 1'b0;
  int                n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Predict this edge's read outputs and advance the model; inputs are stable here.
  task automatic model_step();
    int a;
    logic [DATA_W-1:0] pre_d [NRD];
    logic              pre_b [NRD];
    chk_en = 1'b1;
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin mem[r] = '0; bsy[r] = 1'b0; end
      for (int i = 0; i < NRD; i++) begin exp_d[i] = '0; exp_b[i] = 1'b0; end
      return;
    end
    for (int i = 0; i < NRD; i++) begin
      a = int'(rd_addr[i*ADDR_W +: ADDR_W]);
      pre_d[i] = (a < NREG) ? mem[a] : '0;
      pre_b[i] = (a < NREG) ? bsy[a] : 1'b0;
    end
    // apply lowest priority first: wp1 lanes, then wp0 word; busy clear then set
    if (wp1_en && int'(wp1_addr) < NREG) begin
      for (int k = 0; k < NB; k++)
        if (wp1_be[k]) mem[wp1_addr][8*k +: 8] = wp1_data[8*k +: 8];
      bsy[wp1_addr] = 1'b0;
    end
    if (wp0_en && int'(wp0_addr) < NREG) mem[wp0_addr] = wp0_data;
    if (sb_set && int'(sb_addr) < NREG)  bsy[sb_addr] = 1'b1;
    for (int i = 0; i < NRD; i++) begin
      a = int'(rd_addr[i*ADDR_W +: ADDR_W]);
      exp_d[i] = BYP ? ((a < NREG) ? mem[a] : '0) : pre_d[i];
      exp_b[i] = BYP ? ((a < NREG) ? bsy[a] : 1'b0) : pre_b[i];
    end
  endtask

  // compare every cycle, just after the edge the expectations were built for
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("cyc_rd_data[%0d]", i), rd_data[i*DATA_W +: DATA_W], exp_d[i]);
        chk($sformatf("cyc_rd_busy[%0d]", i), DATA_W'(rd_busy[i]), DATA_W'(exp_b[i]));
      end
    end
  end

  task automatic idle();
    reset = 1'b1; rd_addr = '0;
    wp0_en = 0; wp0_addr = '0; wp0_data = '0;
    wp1_en = 0; wp1_addr = '0; wp1_be = '0; wp1_data = '0;
    sb_set = 0; sb_addr = '0;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic rd_all(input int a);
    for (int i = 0; i < NRD; i++) rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  function automatic logic [ADDR_W-1:0] raddr();
    return $urandom_range(0, 1) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom_range(0, 15));
  endfunction

  initial begin
    idle();
    reset = 1'b0;
    @(negedge clk); tick();
    reset = 1'b1; tick();

    // reset lands on a write in flight
    wp0_en = 1; wp0_addr = 3; wp0_data = 32'hDEADBEEF;
    #2 reset = 1'b0;
    tick(); tick();
    idle(); rd_all(3); tick();
    chk("rst_r3_data", rd_data[DATA_W-1:0], 32'h0);
    chk("rst_r3_busy", DATA_W'(rd_busy[0]), 32'h0);

    idle(); wp0_en = 1; wp0_addr = 5; wp0_data = 32'h12345678; tick();
    idle(); rd_all(5); tick();
    for (int i = 0; i < NRD; i++)
      chk($sformatf("r5_port%0d", i), rd_data[i*DATA_W +: DATA_W], 32'h12345678);

    idle(); wp0_en = 1; wp0_addr = 2; wp0_data = 32'hAABBCCDD; tick();
    idle(); wp1_en = 1; wp1_addr = 2; wp1_be = 4'b0010; wp1_data = 32'h00001100; tick();
    idle(); rd_all(2); tick();
    chk("r2_byte_merge", rd_data[DATA_W-1:0], 32'hAABB11DD);

    idle(); sb_set = 1; sb_addr = 7; tick();
    idle(); wp0_en = 1; wp0_addr = 7; wp0_data = 32'h11111111;
    wp1_en = 1; wp1_addr = 7; wp1_be = 4'hF; wp1_data = 32'h22222222; tick();
    idle(); rd_all(7); tick();
    chk("r7_collide_data", rd_data[DATA_W-1:0], 32'h11111111);
    chk("r7_collide_busy", DATA_W'(rd_busy[0]), 32'h0);

    idle(); sb_set = 1; sb_addr = 4; tick();
    idle(); rd_all(4); tick();
    chk("r4_busy_set", DATA_W'(rd_busy[0]), 32'h1);
    idle(); sb_set = 1; sb_addr = 4; wp1_en = 1; wp1_addr = 4; wp1_be = '0; tick();
    idle(); rd_all(4); tick();
    chk("r4_set_wins", DATA_W'(rd_busy[1]), 32'h1);
    idle(); wp1_en = 1; wp1_addr = 4; wp1_be = '0; tick();
    idle(); rd_all(4); tick();
    chk("r4_busy_clr", DATA_W'(rd_busy[2]), 32'h0);

    idle(); rd_all(9); wp0_en = 1; wp0_addr = 9; wp0_data = 32'hCAFEF00D; tick();
    chk("r9_rdw", rd_data[DATA_W-1:0], BYP ? 32'hCAFEF00D : 32'h0);
    idle(); rd_all(9); tick();
    chk("r9_after", rd_data[DATA_W-1:0], 32'hCAFEF00D);

    idle(); wp0_en = 1; wp0_addr = 15; wp0_data = 32'hFFFFFFFF; sb_set = 1; sb_addr = 15; tick();
    idle(); rd_all(15); tick();
    chk("r15_data", rd_data[2*DATA_W +: DATA_W], 32'h0);
    chk("r15_busy", DATA_W'(rd_busy[2]), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NRD; i++) rd_addr[i*ADDR_W +: ADDR_W] = raddr();
      wp0_en   = $urandom_range(0, 1); wp0_addr = raddr(); wp0_data = $urandom;
      wp1_en   = $urandom_range(0, 1); wp1_addr = raddr(); wp1_data = $urandom;
      wp1_be   = NB'($urandom);
      sb_set   = $urandom_range(0, 1); sb_addr = raddr();
      tick();
    end

    idle(); tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
